ahb_lite_slave_mem: RTL
=======================

# ahb_lite_slave_mem

AHB-Lite responder: a word-addressed memory with a fixed number of wait states, byte/halfword/word write strobing, and an optional two-cycle ERROR response. It sits at the slave end of the AHB bus that the bridge bench's master drives. It is the DUT-side counterpart used to close the master agent's loop and to act as a reference target for bridge comparisons.

## Interface
- ADDR_WIDTH, 32, Haddr width
- DATA_WIDTH, 32, Hwdata/Hrdata width; only 32 is supported
- DEPTH, 256, number of 32-bit words; word index = Haddr[ADDR_WIDTH-1:2]
- WAIT_STATES, 2, data-phase wait cycles per OKAY transfer; legal range 0..7
- Hclk  in  1  clock; all state updates on the rising edge
- Hreset  in  1  asynchronous, active-high reset
- Hsel  in  1  slave select
- Htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- Haddr  in  ADDR_WIDTH  transfer address
- Hwrite  in  1  1 = write
- Hsize  in  3  0 byte, 1 halfword, 2 word
- Hprot  in  4  ignored; no functional effect
- Hwdata  in  DATA_WIDTH  write data, valid in the data phase
- Hreadyin  in  1  bus HREADY; the previous transfer has completed
- Hrdata  out  DATA_WIDTH  read data
- Hreadyout  out  1  slave ready
- Hresp  out  1  0 OKAY, 1 ERROR

## Operation
- Address phase is accepted on a rising edge when Hsel & Hreadyin & Htrans[1]. On acceptance, register Haddr, Hwrite and Hsize, and compute error status.
- IDLE, BUSY, or an unselected cycle: the next data phase is zero-wait OKAY with no memory access.
- FSM states:
  - IDLE: Hreadyout=1, Hresp=0.
  - WAIT: counter loads WAIT_STATES on acceptance and decrements each cycle; Hreadyout=0 while the count is non-zero.
  - ERR1: Hresp=1, Hreadyout=0.
  - ERR2: Hresp=1, Hreadyout=1.
- Transitions:
  - Accepted OKAY transfer goes to WAIT, or completes directly if WAIT_STATES=0.
  - Accepted error transfer goes to ERR1, then ERR2, then IDLE, or to the next accepted transfer.
  - The cycle in which Hreadyout=1 ends the data phase. A new address phase may be accepted on that same edge, which gives back-to-back pipelining.
- Write commit: on the final data-phase edge, write Hwdata into mem[index] using little-endian byte lanes.
  - Byte: lane Haddr[1:0].
  - Halfword: lanes {Haddr[1],0} and {Haddr[1],1}.
  - Word: all four lanes.
- Read: Hrdata presents the full word mem[index] during the final data-phase cycle, and holds its value otherwise.
  - A read whose address phase overlaps a write's data phase to the same word returns the merged (new) data. Forwarding is required.
- Memory is cleared to 0 on reset.

## Timing
- Reset values: Hreadyout=1, Hresp=0, Hrdata=0, FSM=IDLE, wait counter=0.
- Reset is asynchronous: outputs take their reset values immediately. An in-flight write is dropped and the pending transfer is abandoned.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the address-phase edge.
- ERROR: exactly two data-phase cycles, with no wait states, regardless of WAIT_STATES.
- Transfers are ignored while Hreadyin=0, including address phases presented during this slave's own wait or ERR1 cycles.
- If the master drives IDLE during ERR2, the slave returns to IDLE with no further access.
- Out-of-range index (index ≥ DEPTH) with the macro absent: the word index wraps modulo DEPTH.

## Configuration
- Macro: AHB_LITE_SLAVE_ERR_EN.
- Defined, the following accepted transfers take the ERR1/ERR2 path and produce no memory write:
  - index ≥ DEPTH;
  - Hsize>2;
  - misalignment: halfword with Haddr[0]=1, or word with Haddr[1:0]≠0.
- Undefined, no error is ever issued (Hresp tied 0):
  - the index wraps modulo DEPTH;
  - Hsize>2 is treated as a word;
  - misaligned addresses are aligned down by clearing the low bits.

## Test plan
- Reset, then a word write of 0xDEADBEEF to 0x10 followed by a read of 0x10 with WAIT_STATES=2 → Hreadyout low for 2 cycles in each data phase; Hrdata=0xDEADBEEF, Hresp=0.
- Byte write 0xAA to 0x21, then a word read of 0x20 after reset → Hrdata=0x0000AA00.
- Back-to-back write of 0x12345678 to 0x40 immediately followed by a read of 0x40, with pipelined address phases → the read returns 0x12345678 (forwarding check).
- With AHB_LITE_SLAVE_ERR_EN defined: a word access to 0x402 (DEPTH=256) → Hresp=1 with Hreadyout 0 then 1; mem unchanged; the following OKAY transfer completes normally.
- Htrans=BUSY or Hsel=0 at 0x10 → zero-wait OKAY; no memory change.
- Assert Hreset during the second wait cycle of a write of 0xCAFEF00D to 0x08 → Hreadyout=1 immediately; a subsequent read of 0x08 returns 0.

Source files
------------

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory responder with fixed wait states, byte-lane write strobes and read forwarding.
// Define AHB_LITE_SLAVE_ERR_EN to answer out-of-range, oversize and misaligned transfers with ERROR.
module ahb_lite_slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic                  Hsel,
   input  logic [1:0]            Htrans,
   input  logic [ADDR_WIDTH-1:0] Haddr,
   input  logic                  Hwrite,
   input  logic [2:0]            Hsize,
   input  logic [3:0]            Hprot,
   input  logic [DATA_WIDTH-1:0] Hwdata,
   input  logic                  Hreadyin,
   output logic [DATA_WIDTH-1:0] Hrdata,
   output logic                  Hreadyout,
   output logic                  Hresp
);
   // state   | meaning
   // ST_IDLE | no transfer in flight, or zero-wait transfer in its final cycle
   // ST_WAIT | OKAY data phase, Hreadyout low while cnt is non-zero
   // ST_ERR1 | first ERROR cycle, Hreadyout low
   // ST_ERR2 | second ERROR cycle, Hreadyout high
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                state;
   logic [2:0]            cnt;
   logic                  act;
   logic                  wr_q;
   logic [IW-1:0]         idx_q;
   logic [3:0]            strb_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  err;
   logic                  commit;
   logic [31:0]           idx_full;
   logic [IW-1:0]         idx_new;
   logic [3:0]            strb_new;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_new;
   logic                  unused_ok;

   assign unused_ok = ^Hprot;
   assign accept    = Hsel & Hreadyin & Htrans[1];
   assign idx_full  = 32'(Haddr[ADDR_WIDTH-1:2]);
   assign idx_new   = IW'(idx_full % 32'(DEPTH));
   assign commit    = Hreadyout & act & wr_q;

`ifdef AHB_LITE_SLAVE_ERR_EN
   assign err = (idx_full >= 32'(DEPTH)) || (Hsize > 3'd2) ||
                (Hsize == 3'd1 && Haddr[0]) || (Hsize == 3'd2 && Haddr[1:0] != 2'b00);
`else
   assign err = 1'b0;
`endif

   // Lane selection ignores address bits below the access size, which aligns down.
   always_comb begin
      strb_new = 4'b1111;
      case (Hsize)
         3'd0:    strb_new = 4'b0001 << Haddr[1:0];
         3'd1:    strb_new = Haddr[1] ? 4'b1100 : 4'b0011;
         default: strb_new = 4'b1111;
      endcase
   end

   always_comb begin
      merged = mem[idx_q];
      for (int i = 0; i < 4; i++)
         if (strb_q[i]) merged[8*i +: 8] = Hwdata[8*i +: 8];
   end

   // A zero-wait read accepted on the same edge a write commits must see the new word.
   assign rd_new = (commit && idx_q == idx_new) ? merged : mem[idx_new];

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         act       <= 1'b0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         strb_q    <= '0;
         Hreadyout <= 1'b1;
         Hresp     <= 1'b0;
         Hrdata    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (commit) mem[idx_q] <= merged;
         if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            Hreadyout <= 1'b1;
            Hresp     <= 1'b1;
         end else if (state == ST_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
               Hreadyout <= 1'b1;
               if (!wr_q) Hrdata <= mem[idx_q];
            end
         end else begin
            state     <= ST_IDLE;
            act       <= 1'b0;
            Hreadyout <= 1'b1;
            Hresp     <= 1'b0;
            if (accept) begin
               idx_q  <= idx_new;
               wr_q   <= Hwrite;
               strb_q <= strb_new;
               if (err) begin
                  state     <= ST_ERR1;
                  Hreadyout <= 1'b0;
                  Hresp     <= 1'b1;
               end else begin
                  act <= 1'b1;
                  if (WAIT_STATES == 0) begin
                     if (!Hwrite) Hrdata <= rd_new;
                  end else begin
                     state     <= ST_WAIT;
                     cnt       <= 3'(WAIT_STATES);
                     Hreadyout <= 1'b0;
                  end
               end
            end
         end
      end
   end
endmodule
